// File: rtl/pistormx_pkg.sv
// Shared definitions for the Pistorm A600 bus master: E clock phase constants
// and the VPA/VMA peripheral-cycle state encoding.
package pistormx_pkg;

    // E clock shape, counted in M68K_CLK cycles. The bus master uses these to
    // check that S4 lines up with the E phase.
    localparam int unsigned ECLK_E_LOW     = 6;
    localparam int unsigned ECLK_E_HIGH    = 4;
    localparam int unsigned ECLK_SYNC_LOAD = 8;
    localparam int unsigned ECLK_VMA_CNT   = 3;
    localparam int unsigned ECLK_DONE_CNT  = 8;
    localparam int unsigned ECLK_PHASE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_VMA  = 3'd2,
        ST_DONE = 3'd3,
        ST_HOLD = 3'd4
    } vpa_state_t;

    // Advance an E phase count, wrapping after the last phase of the period.
    function automatic logic [ECLK_PHASE_W-1:0] phase_inc(
        input logic [ECLK_PHASE_W-1:0] ph,
        input logic [ECLK_PHASE_W-1:0] last_ph
    );
        return (ph == last_ph) ? '0 : ph + 4'd1;
    endfunction

endpackage

// File: rtl/e_phase_tracker.sv
// E clock phase counter: free-runs over one E period, generates E locally
// or re-aligns to the host E rising edge when tracking.
module e_phase_tracker
    import pistormx_pkg::*;
#(
    parameter int unsigned E_LOW     = ECLK_E_LOW,
    parameter int unsigned E_HIGH    = ECLK_E_HIGH,
    parameter int unsigned SYNC_LOAD = ECLK_SYNC_LOAD
)(
    input  logic                    M68K_CLK,
    input  logic                    M68K_RESET_n,
    input  logic                    e_gen_en,
    input  logic                    e_in,
    output logic                    e_out,
    output logic                    e_locked,
    output logic [ECLK_PHASE_W-1:0] e_phase
);

    localparam logic [ECLK_PHASE_W-1:0] LAST_PH  = ECLK_PHASE_W'(E_LOW + E_HIGH - 1);
    localparam logic [ECLK_PHASE_W-1:0] E_LOW_PH = ECLK_PHASE_W'(E_LOW);
    localparam logic [ECLK_PHASE_W-1:0] LOAD_PH  = ECLK_PHASE_W'(SYNC_LOAD);

    logic [ECLK_PHASE_W-1:0] cnt_q, cnt_d;
    logic [1:0]              sync_q, sync_d;
    logic                    e_out_q, e_out_d;
    logic                    locked_q, locked_d;
    logic                    gen_en_q;
    logic                    e_rise;
    logic                    gen_changed;

    // Next-state logic: count, resync on host E rise, lock tracking, E level.
    always_comb begin
        // Stage 0 captures the pin; stage 1 is its history for edge detection.
        // SYNC_LOAD already accounts for this capture latency.
        sync_d      = {sync_q[0], e_in};
        e_rise      = sync_q[0] & ~sync_q[1];
        gen_changed = e_gen_en ^ gen_en_q;

        cnt_d = phase_inc(cnt_q, LAST_PH);
        if (!e_gen_en && e_rise) begin
            cnt_d = LOAD_PH;
        end

        locked_d = locked_q;
        if (e_gen_en) begin
            locked_d = 1'b1;
        end else if (gen_changed) begin
            locked_d = 1'b0;
        end else if (e_rise) begin
            locked_d = 1'b1;
        end

        // Registered from the next count so E switches together with the phase.
        e_out_d = e_gen_en & (cnt_d >= E_LOW_PH);
    end

    // State registers; sync stages reset high so a high E pin after reset
    // is not mistaken for a rising edge.
    always_ff @(posedge M68K_CLK) begin
        if (!M68K_RESET_n) begin
            cnt_q    <= '0;
            sync_q   <= 2'b11;
            e_out_q  <= 1'b0;
            locked_q <= e_gen_en;
            gen_en_q <= e_gen_en;
        end else begin
            cnt_q    <= cnt_d;
            sync_q   <= sync_d;
            e_out_q  <= e_out_d;
            locked_q <= locked_d;
            gen_en_q <= e_gen_en;
        end
    end

    assign e_out    = e_out_q;
    assign e_locked = locked_q;
    assign e_phase  = cnt_q;

endmodule

// File: rtl/m68k_eclock_vpa.sv
// E clock source/tracker plus 6800-style VPA/VMA cycle sequencer. A VPA
// cycle held in S3 gets a VMA window aligned to E and a one-clock
// completion pulse that stands in for DTACK.
module m68k_eclock_vpa
    import pistormx_pkg::*;
#(
    parameter int unsigned E_LOW     = ECLK_E_LOW,
    parameter int unsigned E_HIGH    = ECLK_E_HIGH,
    parameter int unsigned SYNC_LOAD = ECLK_SYNC_LOAD,
    parameter int unsigned VMA_CNT   = ECLK_VMA_CNT,
    parameter int unsigned DONE_CNT  = ECLK_DONE_CNT
)(
    input  logic                    M68K_CLK,
    input  logic                    M68K_RESET_n,
    input  logic                    e_gen_en,
    input  logic                    e_in,
    output logic                    e_out,
    output logic                    e_oe,
    output logic                    e_locked,
    output logic [ECLK_PHASE_W-1:0] e_phase,
    input  logic                    cyc_active,
    input  logic                    vpa_n,
    output logic                    vma_n,
    output logic                    vpa_done
);

    // Transitions fire one phase early so VMA/DONE are entered exactly at
    // VMA_CNT/DONE_CNT.
    localparam logic [ECLK_PHASE_W-1:0] VMA_PRE_PH  = ECLK_PHASE_W'(VMA_CNT - 1);
    localparam logic [ECLK_PHASE_W-1:0] DONE_PRE_PH = ECLK_PHASE_W'(DONE_CNT - 1);

    vpa_state_t state_q, state_d;
    logic       vma_n_q, vma_n_d;
    logic       vpa_done_q, vpa_done_d;

    e_phase_tracker #(
        .E_LOW     (E_LOW),
        .E_HIGH    (E_HIGH),
        .SYNC_LOAD (SYNC_LOAD)
    ) u_tracker (
        .M68K_CLK     (M68K_CLK),
        .M68K_RESET_n (M68K_RESET_n),
        .e_gen_en     (e_gen_en),
        .e_in         (e_in),
        .e_out        (e_out),
        .e_locked     (e_locked),
        .e_phase      (e_phase)
    );

    // Next state and registered-output decode for the VPA sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cyc_active && !vpa_n && e_locked) begin
                    state_d = ST_ARM;
                end
            end
            // Late VPA simply waits here for the next E period.
            ST_ARM: begin
                if (!cyc_active) begin
                    state_d = ST_IDLE;
                end else if (e_phase == VMA_PRE_PH) begin
                    state_d = ST_VMA;
                end
            end
            // VPA negation is ignored once armed; only an aborted bus cycle
            // stops the sequence.
            ST_VMA: begin
                if (!cyc_active) begin
                    state_d = ST_IDLE;
                end else if (e_phase == DONE_PRE_PH) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = cyc_active ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!cyc_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        vma_n_d    = !((state_d == ST_VMA) || (state_d == ST_DONE) || (state_d == ST_HOLD));
        vpa_done_d = (state_d == ST_DONE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge M68K_CLK) begin
        if (!M68K_RESET_n) begin
            state_q    <= ST_IDLE;
            vma_n_q    <= 1'b1;
            vpa_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vma_n_q    <= vma_n_d;
            vpa_done_q <= vpa_done_d;
        end
    end

    assign e_oe     = e_gen_en;
    assign vma_n    = vma_n_q;
    assign vpa_done = vpa_done_q;

endmodule

// File: tb/tb_m68k_eclock_vpa.sv
// Self-checking bench for m68k_eclock_vpa: vector table, E-aligned latency
// sequences, host-E tracking, and randomized VPA traffic against a
// time-based reference model.
module tb_m68k_eclock_vpa;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gen_en = 1'b1;
    logic       e_in = 1'b0;
    logic       cyc = 1'b0;
    logic       vpa_n = 1'b1;
    logic       e_out, e_oe, e_locked, vma_n, vpa_done;
    logic [3:0] e_phase;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int ext_off = 0;

    always #5 clk = ~clk;

    m68k_eclock_vpa dut (
        .M68K_CLK     (clk),
        .M68K_RESET_n (rst_n),
        .e_gen_en     (gen_en),
        .e_in         (e_in),
        .e_out        (e_out),
        .e_oe         (e_oe),
        .e_locked     (e_locked),
        .e_phase      (e_phase),
        .cyc_active   (cyc),
        .vpa_n        (vpa_n),
        .vma_n        (vma_n),
        .vpa_done     (vpa_done)
    );

    typedef struct {
        logic       rst_n;
        logic       cyc;
        logic       vpa_n;
        logic [3:0] ph;
        logic       vma_n;
        logic       dn;
    } vec_t;

    vec_t vt[$];

    // Host E model: phase of the host 68k, E high for phases 6..9.
    function automatic int ext_ph();
        return (cyc_n + ext_off) % 10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        e_in = (ext_ph() >= 6);
    endtask

    function automatic logic [31:0] pk(input logic [3:0] ph, input logic eo, input logic oe,
                                       input logic lk, input logic vn, input logic dn);
        return {23'd0, ph, eo, oe, lk, vn, dn};
    endfunction

    function automatic logic [31:0] act();
        return pk(e_phase, e_out, e_oe, e_locked, vma_n, vpa_done);
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e, input bit quiet);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, a, e);
        end else if (!quiet) begin
            $display("ok   %s: 0x%0h", name, a);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired, required event not seen", name);
    endtask

    task automatic add(input logic r, input logic c, input logic v, input int ph,
                       input logic vn, input logic dn);
        vec_t x;
        x.rst_n = r; x.cyc = c; x.vpa_n = v; x.ph = 4'(ph); x.vma_n = vn; x.dn = dn;
        vt.push_back(x);
    endtask

    // Wait (bounded) until the visible E phase equals p.
    task automatic wait_ph(input int p, output bit ok);
        int n = 0;
        while (e_phase != 4'(p) && n < 12) begin
            tick();
            n++;
        end
        ok = (e_phase == 4'(p));
    endtask

    // Recognise VPA at phase p and measure clocks until vpa_done.
    task automatic vpa_lat(input int p, input int exp_d, input int rel);
        bit ok;
        int n;
        wait_ph(p, ok);
        if (!ok) begin
            timeout($sformatf("lat_p%0d_align", p));
            return;
        end
        cyc = 1'b1;
        vpa_n = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (rel != 0 && n == rel) vpa_n = 1'b1;
        end while (!vpa_done && n < 40);
        chk($sformatf("lat_p%0d", p), n, exp_d, 1'b0);
        tick();
        chk($sformatf("hold_p%0d {vma_n,done}", p), {vma_n, vpa_done}, 2'b00, 1'b0);
        cyc = 1'b0;
        vpa_n = 1'b1;
        tick();
        chk($sformatf("release_p%0d {vma_n,done}", p), {vma_n, vpa_done}, 2'b10, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int rc;
        int ph_now;
        int d;
        int t_vma;
        int t_done;
        bit busy;
        logic [31:0] e;

        // ---------------- vector table (generate mode) ----------------
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) add(1'b1, 1'b0, 1'b1, k % 10, 1'b1, 1'b0);
        // VPA recognised at phase 0: VMA from phase 3, done at phase 8, then hold.
        for (int k = 1; k <= 10; k++) add(1'b1, 1'b1, 1'b0, k % 10, (k >= 3) ? 1'b0 : 1'b1, (k == 8));
        add(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0);
        // VPA at phase 1, aborted while VMA is low: no completion pulse.
        add(1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0);
        for (int k = 6; k <= 9; k++) add(1'b1, 1'b0, 1'b1, k, 1'b1, 1'b0);

        gen_en = 1'b1;
        foreach (vt[i]) begin
            rst_n = vt[i].rst_n;
            cyc   = vt[i].cyc;
            vpa_n = vt[i].vpa_n;
            tick();
            e = pk(vt[i].ph, (vt[i].ph >= 4'd6), 1'b1, 1'b1, vt[i].vma_n, vt[i].dn);
            chk($sformatf("tbl%0d", i), act(), e, 1'b0);
        end

        // ---------------- latency from recognition phase ----------------
        vpa_lat(0, 8, 4);   // VPA negated mid-cycle: still completes
        vpa_lat(1, 7, 0);
        vpa_lat(2, 16, 0);  // worst case
        vpa_lat(3, 15, 0);
        vpa_lat(5, 13, 0);
        vpa_lat(9, 9, 0);

        // ---------------- reset while holding ----------------
        wait_ph(0, ok);
        if (!ok) timeout("rst_hold_align");
        cyc = 1'b1;
        vpa_n = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("rst_hold_pre {vma_n,done}", {vma_n, vpa_done}, 2'b00, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("rst_hold", act(), pk(4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        cyc = 1'b0;
        vpa_n = 1'b1;
        rst_n = 1'b1;

        // ---------------- track host E ----------------
        gen_en = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("trk_reset", act(), pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        rst_n = 1'b1;
        ext_off = (13 - (cyc_n % 10)) % 10;   // host phase 3 while local count is 0
        e_in = (ext_ph() >= 6);
        n = 0;
        while (!e_locked && n < 30) begin
            tick();
            n++;
        end
        if (!e_locked) timeout("trk_lock");
        chk("trk_lock_phase", e_phase, 32'd8, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("trk_follow%0d", i), act(), pk(4'(ext_ph()), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
        end
        gen_en = 1'b1;
        tick();
        chk("trk_gen {oe,lk}", {e_oe, e_locked}, 2'b11, 1'b0);
        gen_en = 1'b0;
        tick();
        chk("trk_unlock {oe,lk,eo}", {e_oe, e_locked, e_out}, 3'b000, 1'b0);
        n = 0;
        while (!e_locked && n < 30) begin
            tick();
            n++;
        end
        if (!e_locked) timeout("trk_relock");
        chk("trk_relock_phase", e_phase, 32'(ext_ph()), 1'b0);

        // ---------------- randomized traffic vs model ----------------
        gen_en = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rc = 0;
        busy = 1'b0;
        t_vma = 0;
        t_done = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!cyc) begin
                if ($urandom_range(3) == 0) begin
                    cyc = 1'b1;
                    vpa_n = ($urandom_range(9) < 7) ? 1'b0 : 1'b1;
                end
            end else begin
                if ($urandom_range(11) == 0) begin
                    cyc = 1'b0;
                    vpa_n = 1'b1;
                end else if ($urandom_range(7) == 0) begin
                    vpa_n = ~vpa_n;
                end
            end
            // Model: VMA opens at the first phase 3 at least two clocks after
            // recognition, completion five clocks later; a dropped cycle ends it.
            ph_now = rc % 10;
            if (busy) begin
                if (!cyc) busy = 1'b0;
            end else if (cyc && !vpa_n) begin
                busy = 1'b1;
                d = 2;
                while ((ph_now + d) % 10 != 3) d++;
                t_vma = rc + d;
                t_done = rc + d + 5;
            end
            tick();
            rc++;
            e = pk(4'(rc % 10), ((rc % 10) >= 6), 1'b1, 1'b1,
                   !(busy && rc >= t_vma), (busy && rc == t_done));
            chk($sformatf("rnd%0d", i), act(), e, 1'b1);
            if (busy && rc == t_done) $display("rnd txn completed at clock %0d", rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
